// File: rtl/rll_key_pkg.sv
// rll_key_pkg: shared types and constants for the RLL key loader.
//   state_e            - loader FSM state encoding
//   DEFAULT_KEY_WIDTH  - default number of key bits delivered to the locked netlist
//   cnt_width()        - bit counter width able to hold 0..KEY_WIDTH without wrapping
package rll_key_pkg;

  localparam int DEFAULT_KEY_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/rll_key_shreg.sv
// rll_key_shreg: shadow key register plus bit counter.
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the shadow and the counter (wins over shift_en)
//   shift_en  - write bit_in into data[count], then count++
//   bit_in    - serial key bit
//   data      - staged key (LSB first)
//   count     - number of bits accepted since the last clear
module rll_key_shreg
  import rll_key_pkg::*;
#(
  parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH,
  localparam int CW = cnt_width(KEY_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [KEY_WIDTH-1:0] data,
  output logic [CW-1:0]        count
);

  logic [KEY_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]        count_q, count_d;

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (clear) begin
      data_d  = '0;
      count_d = '0;
    end else if (shift_en && (count_q < CW'(KEY_WIDTH))) begin
      // Saturating guard: a full register never wraps back to bit 0.
      for (int i = 0; i < KEY_WIDTH; i++) begin
        if (count_q == CW'(i)) data_d[i] = bit_in;
      end
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data  = data_q;
  assign count = count_q;

endmodule

// File: rtl/rll_key_loader.sv
// rll_key_loader: serial key loader for a logic-locked netlist.
//   clk, rst        - clock, synchronous active-high reset
//   load_start      - begin (or restart) a key load
//   key_bit         - serial key data, LSB first
//   key_bit_valid   - key_bit valid this cycle
//   key_bit_ready   - loader accepts a bit this cycle (registered state decode)
//   commit          - move the staged key to key_out (legal only when ARMED)
//   abort           - discard the staged key
//   key_out         - committed key; bit i drives keyIn_0_i of the locked netlist
//   key_valid       - key_out holds a committed key
//   busy            - state is not IDLE
//   cmd_err         - one-cycle pulse: commit arrived outside ARMED
//
// state    | meaning
// ST_IDLE  | no load in progress, key_out holds last committed key
// ST_SHIFT | accepting serial bits into the shadow register
// ST_ARMED | all KEY_WIDTH bits staged, waiting for commit
//
// Command priority is abort > commit > load_start. An illegal commit still
// takes precedence over load_start, so that cycle leaves the state unchanged.
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 key_bit,
  input  logic                 key_bit_valid,
  output logic                 key_bit_ready,
  input  logic                 commit,
  input  logic                 abort,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam int CW = cnt_width(KEY_WIDTH);

  state_e               state_q, state_d;
  logic                 ready_q, busy_q, cmd_err_q, cmd_err_d;
  logic [KEY_WIDTH-1:0] key_out_q, key_out_d;
  logic                 key_valid_q, key_valid_d;
  logic                 sh_clear, sh_shift;
  logic [KEY_WIDTH-1:0] shadow;
  logic [CW-1:0]        count;

  rll_key_shreg #(.KEY_WIDTH(KEY_WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clear    (sh_clear),
    .shift_en (sh_shift),
    .bit_in   (key_bit),
    .data     (shadow),
    .count    (count)
  );

  always_comb begin
    state_d     = state_q;
    sh_clear    = 1'b0;
    sh_shift    = 1'b0;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
    cmd_err_d   = commit && !abort && (state_q != ST_ARMED);

    case (state_q)
      ST_IDLE: begin
        if (load_start && !abort && !commit) begin
          state_d  = ST_SHIFT;
          sh_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d  = ST_IDLE;
          sh_clear = 1'b1;
        end else if (commit) begin
          // illegal here: flagged via cmd_err, otherwise ignored
          state_d = ST_SHIFT;
        end else if (load_start) begin
          sh_clear = 1'b1;
        end else if (key_bit_valid && ready_q) begin
          sh_shift = 1'b1;
          if (count == CW'(KEY_WIDTH - 1)) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_d  = ST_IDLE;
          sh_clear = 1'b1;
        end else if (commit) begin
          state_d     = ST_IDLE;
          key_out_d   = shadow;
          key_valid_d = 1'b1;
        end else if (load_start) begin
          state_d  = ST_SHIFT;
          sh_clear = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sh_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      // decoded from next state so ready/busy line up with the state register
      ready_q     <= (state_d == ST_SHIFT);
      busy_q      <= (state_d != ST_IDLE);
      cmd_err_q   <= cmd_err_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_bit_ready = ready_q;
  assign busy          = busy_q;
  assign cmd_err       = cmd_err_q;
  assign key_out       = key_out_q;
  assign key_valid     = key_valid_q;

endmodule

// File: tb/tb_rll_key_loader.sv
module tb_rll_key_loader;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          key_bit = 1'b0;
  logic          key_bit_valid = 1'b0;
  logic          key_bit_ready;
  logic          commit = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  key_out;
  logic          key_valid;
  logic          busy;
  logic          cmd_err;

  int n_vec = 0;
  int n_err = 0;

  rll_key_loader #(.KEY_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .key_bit       (key_bit),
    .key_bit_valid (key_bit_valid),
    .key_bit_ready (key_bit_ready),
    .commit        (commit),
    .abort         (abort),
    .key_out       (key_out),
    .key_valid     (key_valid),
    .busy          (busy),
    .cmd_err       (cmd_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a load in progress is a queue of received bits;
  // it is armed exactly when the queue holds W bits.
  bit           m_loading = 1'b0;
  bit           m_bits[$];
  logic [W-1:0] m_key = '0;
  bit           m_valid = 1'b0;
  bit           m_err = 1'b0;

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] v = '0;
    foreach (m_bits[i]) v[i] = m_bits[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_loading = 1'b0;
      m_bits.delete();
      m_key   = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      m_err = commit && !abort && !(m_loading && m_bits.size() == W);
      if (m_loading) begin
        if (abort) begin
          m_loading = 1'b0;
          m_bits.delete();
        end else if (commit) begin
          if (m_bits.size() == W) begin
            m_key     = pack_bits();
            m_valid   = 1'b1;
            m_loading = 1'b0;
          end
        end else if (load_start) begin
          m_bits.delete();
        end else if (key_bit_valid && m_bits.size() < W) begin
          m_bits.push_back(key_bit);
        end
      end else if (load_start && !abort && !commit) begin
        m_loading = 1'b1;
        m_bits.delete();
      end
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("key_out", key_out, m_key);
    check("key_valid", W'(key_valid), W'(m_valid));
    check("busy", W'(busy), W'(m_loading));
    check("key_bit_ready", W'(key_bit_ready), W'(m_loading && m_bits.size() < W));
    check("cmd_err", W'(cmd_err), W'(m_err));
  end

  task automatic cyc(input logic r, input logic ls, input logic kv, input logic kb,
                     input logic cm, input logic ab);
    @(negedge clk);
    rst = r; load_start = ls; key_bit_valid = kv; key_bit = kb; commit = cm; abort = ab;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_bits(input logic [W-1:0] v, input int n);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, v[i], 0, 0);
  endtask

  task automatic load_commit(input logic [W-1:0] v);
    load_bits(v, W);
    cyc(0, 0, 0, 0, 1, 0);
    idle();
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle();
    check("reset key_out", key_out, 32'h0);
    check("reset busy", W'(busy), 32'h0);

    // Basic load and commit
    load_commit(32'hA5A50F0F);
    check("commit A5A50F0F", key_out, 32'hA5A50F0F);
    check("commit valid", W'(key_valid), 32'h1);
    check("commit busy", W'(busy), 32'h0);

    // Abort after partial load keeps the committed key
    load_commit(32'h12345678);
    load_bits(32'hFFFFFFFF, 10);
    check("mid-load key_out held", key_out, 32'h12345678);
    cyc(0, 0, 0, 0, 0, 1);
    idle();
    check("abort key_out", key_out, 32'h12345678);
    check("abort valid", W'(key_valid), 32'h1);
    check("abort busy", W'(busy), 32'h0);

    // Toggling valid, extra bits ignored after the 32nd
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) cyc(0, 0, (i % 2) == 0, 1'b1, 0, 0);
    idle();
    check("armed ready", W'(key_bit_ready), 32'h0);
    check("armed busy", W'(busy), 32'h1);
    cyc(0, 0, 0, 0, 1, 0);
    idle();
    check("toggle commit", key_out, 32'hFFFFFFFF);

    // Commit in IDLE: one-cycle cmd_err
    cyc(0, 0, 0, 0, 1, 0);
    idle();
    check("idle commit err", W'(cmd_err), 32'h1);
    check("idle commit key", key_out, 32'hFFFFFFFF);
    idle();
    check("err one cycle", W'(cmd_err), 32'h0);

    // Commit + abort in ARMED: abort wins
    load_bits(32'h0BADF00D, W);
    cyc(0, 0, 0, 0, 1, 1);
    idle();
    check("abort beats commit", key_out, 32'hFFFFFFFF);
    check("abort beats commit busy", W'(busy), 32'h0);

    // Reset mid-load, then a fresh load
    load_bits(32'hDEADBEEF, 16);
    cyc(1, 0, 0, 0, 0, 0);
    idle();
    check("rst key_out", key_out, 32'h0);
    check("rst valid", W'(key_valid), 32'h0);
    check("rst busy", W'(busy), 32'h0);
    check("rst ready", W'(key_bit_ready), 32'h0);
    load_commit(32'h00000001);
    check("post-rst commit", key_out, 32'h00000001);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic ls, cm, ab, rr;
      r  = $urandom_range(0, 999);
      ls = (r < 8) || (r >= 30 && r < 34);
      cm = (r >= 8 && r < 24) || (r >= 28 && r < 34);
      ab = (r >= 24 && r < 30);
      rr = (r == 999);
      cyc(rr, ls, $urandom_range(0, 9) < 7, 1'($urandom), cm, ab);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rll_key_loader.md
RLL_KEY_LOADER -- requirements
Module: rll_key_loader

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32: number of key bits delivered to the locked netlist.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port load_start, input, 1: single-cycle request to begin a new key load.
REQ-005 SHALL have port key_bit, input, 1: serial key data, LSB first.
REQ-006 SHALL have port key_bit_valid, input, 1: key_bit is valid this cycle.
REQ-007 SHALL have port key_bit_ready, output, 1: loader accepts a bit this cycle.
REQ-008 SHALL have port commit, input, 1: transfer the staged key to the output.
REQ-009 SHALL have port abort, input, 1: discard the staged key.
REQ-010 SHALL have port key_out, output, KEY_WIDTH: key bus; bit i drives keyIn_0_i of the locked netlist.
REQ-011 SHALL have port key_valid, output, 1: key_out holds a committed key.
REQ-012 SHALL have port busy, output, 1: state is not IDLE.
REQ-013 SHALL have port cmd_err, output, 1: one-cycle pulse flagging an illegal command.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and ARMED.
REQ-015 IDLE SHALL move to SHIFT on load_start, clearing the shadow register and the bit counter.
REQ-016 key_bit_ready SHALL be 1 only in SHIFT, as a registered state decode with no combinational path from key_bit_valid.
REQ-017 On valid&ready, the loader SHALL write key_bit into shadow[count], then count <= count+1.
REQ-018 When the KEY_WIDTH-th bit is accepted, the FSM SHALL enter ARMED on that same edge, and key_bit_ready SHALL be 0 on the next cycle.
REQ-019 The counter SHALL be $clog2(KEY_WIDTH)+1 bits wide and SHALL never wrap; further valid bits outside SHIFT SHALL be ignored.
REQ-020 In ARMED, on commit, key_out SHALL be loaded from shadow, key_valid SHALL be set to 1 and the FSM SHALL return to IDLE, all on the same edge.
REQ-021 key_out SHALL change only on commit or rst and SHALL otherwise hold the previous committed key, including throughout SHIFT.
REQ-022 abort in SHIFT or ARMED SHALL return the FSM to IDLE and clear the shadow, leaving key_out and key_valid unchanged.
REQ-023 Command priority SHALL be abort > commit > load_start when they coincide.
REQ-024 load_start in SHIFT SHALL restart the load: shadow and count are cleared and the state stays SHIFT.
REQ-025 load_start in ARMED SHALL restart the load as in REQ-024 unless commit is also asserted.
REQ-026 commit outside ARMED SHALL be ignored and SHALL pulse cmd_err for exactly one cycle, registered.
REQ-027 key_bit_valid asserted in SHIFT on a cycle that also carries load_start or abort SHALL be dropped.
REQ-028 busy SHALL be (state != IDLE), registered.

Reset
REQ-029 On rst the FSM SHALL return to IDLE and key_out, shadow, count, key_valid, key_bit_ready, busy and cmd_err SHALL all be 0.
REQ-030 rst during SHIFT or ARMED SHALL discard any partial key; rst SHALL override every other input.

Structure
REQ-031 Package rll_key_pkg SHALL hold the state enum type and the default KEY_WIDTH constant.
REQ-032 The shadow register plus counter SHALL be one sub-module, rll_key_shreg, with ports clear, shift_en, bit_in, data and count.
REQ-033 The FSM, output register and error logic SHALL reside in rll_key_loader.

Verification
REQ-034 Reset, load_start, then 32 valid bits of 0xA5A50F0F LSB first, then commit -> key_out=0xA5A50F0F and key_valid=1 on the edge after commit; busy=0.
REQ-035 Commit 0x12345678, then load_start and 10 bits, then abort -> key_out stays 0x12345678, key_valid=1 and state is IDLE.
REQ-036 Valid bits toggling 1/0 every cycle during a load of 0xFFFFFFFF -> exactly 32 bits are accepted, key_bit_ready=0 after the 32nd, extra bits are ignored and the committed key equals 0xFFFFFFFF.
REQ-037 commit in IDLE -> cmd_err=1 for exactly one cycle and key_out unchanged; commit together with abort in ARMED -> abort wins and key_out is unchanged.
REQ-038 rst asserted after 16 of 32 bits of 0xDEADBEEF -> all outputs 0 on the next cycle; a fresh load of 0x00000001 then commits correctly.
